// File: rtl/counter_pkg.sv
// Shared definitions for the board-level counter family: direction encoding
// and the elaboration-time modulus legality check.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // A modulus is legal when the counter can hold every value 0..MODULUS-1
    // and there are at least two states to move between.
    function automatic bit modulus_legal(input int unsigned width,
                                         input longint unsigned modulus);
        if (width == 0 || width > 62) begin
            return 1'b0;
        end
        return (modulus >= 64'd2) && (modulus <= (64'd1 << width));
    endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector on a level input. The history register resets to a
// configurable value so a level already high at reset release is not an edge.
module edge_detect_rise #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic rise_o
);

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = level_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= RESET_VAL;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign rise_o = level_i & ~hist_q;

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with load, wrap/saturate limits,
// optional single-step advance, terminal count and wrap/overflow flags.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MODULUS   = 256,
    parameter bit SATURATE  = 1'b0,
    parameter bit STEP_MODE = 1'b0
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Enable,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Step,
    output logic [WIDTH-1:0] Q,
    output logic             Tc,
    output logic             Wrap,
    output logic             Ovf
);

    if (!modulus_legal(WIDTH, MODULUS)) begin : g_illegal_modulus
        $fatal(1, "counter_updown_mod: MODULUS out of range for WIDTH");
    end

    // Limits are held one bit wider so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic             step_rise;
    logic             advance;
    logic             at_max;
    logic             at_min;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH-1:0] d_clamped;

    edge_detect_rise #(
        .RESET_VAL (1'b1)
    ) u_step_edge (
        .clk_i   (Clk),
        .rst_i   (Clr),
        .level_i (Step),
        .rise_o  (step_rise)
    );

    assign advance   = Enable & (STEP_MODE ? step_rise : 1'b1);
    assign at_max    = ({1'b0, q_q} == MAX_EXT);
    assign at_min    = (q_q == '0);
    assign d_ext     = {1'b0, D};
    assign d_clamped = (d_ext < MOD_EXT) ? D : MAX_Q;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (Load) begin
            q_d   = d_clamped;
            ovf_d = 1'b0;
        end else if (advance) begin
            if (Up == DIR_UP) begin
                if (!at_max) begin
                    q_d = q_q + WIDTH'(1);
                end else if (SATURATE) begin
                    ovf_d = 1'b1;
                end else begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    q_d = q_q - WIDTH'(1);
                end else if (SATURATE) begin
                    ovf_d = 1'b1;
                end else begin
                    q_d    = MAX_Q;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    // Tc ignores STEP_MODE so a downstream stage can use it as its enable.
    assign Tc   = Enable & ((Up == DIR_UP) ? at_max : at_min);
    assign Q    = q_q;
    assign Wrap = wrap_q;
    assign Ovf  = ovf_q;

endmodule
